// File: rtl/chk_pkg.sv
// chk_pkg: shared types and constants for the memory-write checker.
//   chk_state_e : checker FSM state encoding (LOAD, RUN, PASS, FAIL)
//   ERR_*       : err_code values reported by mem_write_checker
package chk_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } chk_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

endpackage

// File: rtl/chk_fifo.sv
// chk_fifo: synchronous FIFO holding expected (address, data) entries.
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - asynchronous active-high reset, empties the FIFO
//   push_i  - write data_i (ignored when full)
//   data_i  - entry to write
//   pop_i   - drop the head entry (ignored when empty)
//   full_o  - no free entry
//   empty_o - no valid entry
//   head_o  - oldest entry, valid when empty_o is low
module chk_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  // One extra pointer bit separates full from empty when the indices match.
  localparam int unsigned PW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PW-1:0]    wptr_q, rptr_q;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign head_o  = mem_q[rptr_q[PW-2:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[PW-2:0]] <= data_i;
  end

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares CPU stores against a preloaded ordered list of
// expected (address, data) stores and reports pass / fail / timeout.
// Optional macro MISMATCH_CAPTURE_EN adds fail_addr_o/fail_data_o/fail_index_o,
// which latch the offending store and the match count on a mismatch.
// Ports:
//   clk_i, reset_i          - clock; asynchronous active-high reset
//   exp_valid_i/exp_ready_o - expected-entry push handshake (LOAD only)
//   exp_addr_i, exp_data_i  - expected store
//   start_i                 - LOAD -> RUN pulse
//   mem_we_i, mem_addr_i,
//   mem_wdata_i             - observed CPU store
//   done_o, pass_o          - terminal state reached / terminal state is PASS
//   err_code_o              - ERR_NONE/MISMATCH/TIMEOUT/OVERFLOW
//   match_count_o           - stores matched so far
module mem_write_checker
  import chk_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   DEPTH    = 8,
  parameter logic [AW-1:0] IGN_BASE = AW'(32'd96),
  parameter logic [AW-1:0] IGN_MASK = AW'(32'hFFFF_FFFC),
  parameter int unsigned   TIMEOUT  = 100000
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       exp_valid_i,
  output logic                       exp_ready_o,
  input  logic [AW-1:0]              exp_addr_i,
  input  logic [DW-1:0]              exp_data_i,
  input  logic                       start_i,
  input  logic                       mem_we_i,
  input  logic [AW-1:0]              mem_addr_i,
  input  logic [DW-1:0]              mem_wdata_i,
`ifdef MISMATCH_CAPTURE_EN
  output logic [AW-1:0]              fail_addr_o,
  output logic [DW-1:0]              fail_data_o,
  output logic [$clog2(DEPTH)-1:0]   fail_index_o,
`endif
  output logic                       done_o,
  output logic                       pass_o,
  output logic [1:0]                 err_code_o,
  output logic [$clog2(DEPTH+1)-1:0] match_count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  chk_state_e    state_q;
  logic          overflow_q;
  logic [31:0]   tmo_q;
  logic [1:0]    err_q;
  logic [CW-1:0] match_q;

  logic               fifo_full, fifo_empty, push, pop;
  logic [AW+DW-1:0]   fifo_head;
  logic [AW-1:0]      head_addr;
  logic [DW-1:0]      head_data;
  logic               in_load, in_run, ignored, store_ev, hit, timeout_hit;

  assign {head_addr, head_data} = fifo_head;

  assign in_load     = (state_q == ST_LOAD);
  assign in_run      = (state_q == ST_RUN);
  assign exp_ready_o = in_load && !fifo_full;
  assign push        = exp_valid_i && exp_ready_o;

  assign ignored  = ((mem_addr_i & IGN_MASK) == (IGN_BASE & IGN_MASK));
  // A store is judged only while entries remain; the empty cycle resolves to PASS.
  assign store_ev = in_run && !fifo_empty && mem_we_i && !ignored;
  assign hit      = (mem_addr_i == head_addr) && (mem_wdata_i == head_data);
  assign pop      = store_ev && hit;

  assign timeout_hit = (TIMEOUT != 0) && (tmo_q == 32'(TIMEOUT - 1));

  chk_fifo #(
    .Width(AW + DW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .push_i (push),
    .data_i ({exp_addr_i, exp_data_i}),
    .pop_i  (pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

`ifdef MISMATCH_CAPTURE_EN
  logic [AW-1:0]            fail_addr_q;
  logic [DW-1:0]            fail_data_q;
  logic [$clog2(DEPTH)-1:0] fail_index_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_index_q <= '0;
    end else if (store_ev && !hit) begin
      fail_addr_q  <= mem_addr_i;
      fail_data_q  <= mem_wdata_i;
      fail_index_q <= match_q[$clog2(DEPTH)-1:0];
    end
  end

  assign fail_addr_o  = fail_addr_q;
  assign fail_data_o  = fail_data_q;
  assign fail_index_o = fail_index_q;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_LOAD;
      overflow_q <= 1'b0;
      tmo_q      <= '0;
      err_q      <= ERR_NONE;
      match_q    <= '0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (exp_valid_i && fifo_full) overflow_q <= 1'b1;
          if (start_i) begin
            tmo_q <= '0;
            if (overflow_q) begin
              state_q <= ST_FAIL;
              err_q   <= ERR_OVERFLOW;
            end else if (fifo_empty) begin
              state_q <= ST_PASS;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          tmo_q <= tmo_q + 32'd1;
          // Store outcome outranks a timeout landing on the same edge.
          if (fifo_empty) begin
            state_q <= ST_PASS;
          end else if (store_ev && hit) begin
            match_q <= match_q + 1'b1;
          end else if (store_ev) begin
            state_q <= ST_FAIL;
            err_q   <= ERR_MISMATCH;
          end else if (timeout_hit) begin
            state_q <= ST_FAIL;
            err_q   <= ERR_TIMEOUT;
          end
        end
        ST_PASS, ST_FAIL: begin
        end
      endcase
    end
  end

  assign done_o        = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass_o        = (state_q == ST_PASS);
  assign err_code_o    = err_q;
  assign match_count_o = match_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed-vector bench for mem_write_checker
// (DEPTH=8, default ignore window at 96, TIMEOUT=50).
module tb_mem_write_checker;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          start = 1'b0;
  logic          mem_we = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic          done, pass;
  logic [1:0]    err_code;
  logic [3:0]    match_count;
`ifdef MISMATCH_CAPTURE_EN
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [2:0]    fail_index;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_write_checker #(
    .AW(AW),
    .DW(DW),
    .DEPTH(DEPTH),
    .TIMEOUT(50)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .exp_valid_i  (exp_valid),
    .exp_ready_o  (exp_ready),
    .exp_addr_i   (exp_addr),
    .exp_data_i   (exp_data),
    .start_i      (start),
    .mem_we_i     (mem_we),
    .mem_addr_i   (mem_addr),
    .mem_wdata_i  (mem_wdata),
`ifdef MISMATCH_CAPTURE_EN
    .fail_addr_o  (fail_addr),
    .fail_data_o  (fail_data),
    .fail_index_o (fail_index),
`endif
    .done_o       (done),
    .pass_o       (pass),
    .err_code_o   (err_code),
    .match_count_o(match_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_valid = 1'b1;
    exp_addr  = a;
    exp_data  = d;
    step();
    exp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    step();
    mem_we = 1'b0;
  endtask

  initial begin
    step();
    do_reset();
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_err", err_code, 0);
    check_eq("rst_match", match_count, 0);
    check_eq("rst_ready", exp_ready, 1);

    // Ignored scratch store, then the single expected store.
    push(100, 25);
    do_start();
    check_eq("run_ready", exp_ready, 0);
    store(96, 7);
    check_eq("ign_done", done, 0);
    check_eq("ign_match", match_count, 0);
    store(100, 25);
    check_eq("t1_match_pop", match_count, 1);
    check_eq("t1_done_pop", done, 0);
    step();
    check_eq("t1_done", done, 1);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_err", err_code, 0);
    check_eq("t1_match", match_count, 1);

    // Out-of-order store is a mismatch.
    do_reset();
    push(4, 1);
    push(8, 2);
    push(12, 3);
    do_start();
    exp_valid = 1'b1;
    step();
    exp_valid = 1'b0;
    check_eq("run_push_ignored_ready", exp_ready, 0);
    store(4, 1);
    store(12, 3);
    check_eq("t2_done", done, 1);
    check_eq("t2_pass", pass, 0);
    check_eq("t2_err", err_code, 1);
    check_eq("t2_match", match_count, 1);
`ifdef MISMATCH_CAPTURE_EN
    check_eq("t2_fail_addr", fail_addr, 12);
    check_eq("t2_fail_data", fail_data, 3);
    check_eq("t2_fail_index", fail_index, 1);
`endif
    do_start();
    store(8, 2);
    check_eq("t2_sticky_err", err_code, 1);
    check_eq("t2_sticky_match", match_count, 1);

    // Overflow on the ninth push.
    do_reset();
    for (int i = 0; i < 8; i++) push(AW'(16 + 4 * i), DW'(i));
    check_eq("t3_full_ready", exp_ready, 0);
    push(48, 99);
    do_start();
    check_eq("t3_done", done, 1);
    check_eq("t3_pass", pass, 0);
    check_eq("t3_err", err_code, 3);
    check_eq("t3_match", match_count, 0);

    // Timeout fires 50 edges after start.
    do_reset();
    push(200, 5);
    do_start();
    repeat (49) step();
    check_eq("t4_done_49", done, 0);
    step();
    check_eq("t4_done_50", done, 1);
    check_eq("t4_err", err_code, 2);

    // A match on the timeout edge wins.
    do_reset();
    push(200, 5);
    do_start();
    repeat (49) step();
    store(200, 5);
    check_eq("t4b_done", done, 0);
    check_eq("t4b_match", match_count, 1);
    step();
    check_eq("t4b_pass", pass, 1);
    check_eq("t4b_err", err_code, 0);

    // Full queue drained in order, then reload with five entries.
    do_reset();
    for (int i = 0; i < 8; i++) push(AW'(32'h200 + 4 * i), DW'(32'h10 + i));
    store(32'h200, 32'h10);
    check_eq("load_store_ignored", match_count, 0);
    do_start();
    for (int i = 0; i < 8; i++) store(AW'(32'h200 + 4 * i), DW'(32'h10 + i));
    step();
    check_eq("t5_pass8", pass, 1);
    check_eq("t5_match8", match_count, 8);
    do_reset();
    for (int i = 0; i < 5; i++) push(AW'(32'h300 + 4 * i), DW'(32'h20 + i));
    do_start();
    for (int i = 0; i < 5; i++) store(AW'(32'h300 + 4 * i), DW'(32'h20 + i));
    step();
    check_eq("t5_pass5", pass, 1);
    check_eq("t5_match5", match_count, 5);

    // Reset mid-run after two matches.
    do_reset();
    for (int i = 0; i < 4; i++) push(AW'(32'h400 + 4 * i), DW'(i + 1));
    do_start();
    store(32'h400, 1);
    store(32'h404, 2);
    check_eq("t6_match2", match_count, 2);
    reset = 1'b1;
    #1;
    check_eq("t6_async_match", match_count, 0);
    check_eq("t6_async_done", done, 0);
    check_eq("t6_async_ready", exp_ready, 1);
    step();
    reset = 1'b0;
    step();
    check_eq("t6_ready", exp_ready, 1);
    do_start();
    check_eq("t6_empty_pass", pass, 1);
    check_eq("t6_empty_match", match_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
